udp_echo_ctrl: RTL

//  User-side peer of the eth core's UDP interface: captures each received UDP payload
//  (udp_rx_*) into a single-frame byte buffer, validates it, then sends it back unchanged

---
 rtl/udp_echo_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/udp_echo_ctrl.sv
// UDP loopback peer for the eth core: buffers one received payload, checks its length,
// then replays it through the core's udp_tx request/data handshake.
`timescale 1ns/1ps
module udp_echo_ctrl #(
  parameter int BUF_DEPTH  = 2048,
  parameter int ADDR_W     = 11,
  parameter int TX_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        udp_rx_data_vld,
  input  logic [7:0]  udp_rx_data,
  input  logic        udp_rx_done,
  input  logic [15:0] udp_rx_data_num,
  input  logic        tx_rdy,
  input  logic        udp_tx_req,
  output logic        udp_tx_en,
  output logic [7:0]  udp_tx_data,
  output logic [15:0] udp_tx_data_num,
  output logic        busy,
  output logic [15:0] echo_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RX       = 2'd1,
    WAIT_RDY = 2'd2,
    TX       = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_DEPTH - 1);
  localparam logic [15:0]       TMO_LAST  = 16'(TX_TIMEOUT - 1);

  state_t            state_r;
  logic [7:0]        mem_r [BUF_DEPTH];
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              ovf_r;
  logic [15:0]       len_r;
  logic [15:0]       req_cnt_r;
  logic [15:0]       idle_cnt_r;

  logic              rx_phase_s;
  logic              wr_fire_s;
  logic              ovf_next_s;
  logic [15:0]       rx_cnt_s;
  logic              accept_s;
  logic              rd_fire_s;
  logic              last_fire_s;
  logic              extra_req_s;
  logic              timeout_s;
  logic              drop_inc_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Decode of write/read events; a byte arriving with done is counted before the length check.
  always_comb begin
    rx_phase_s  = (state_r == IDLE) || (state_r == RX);
    wr_fire_s   = rx_phase_s && udp_rx_data_vld && !ovf_r;
    ovf_next_s  = ovf_r || (wr_fire_s && (wr_addr_r == LAST_ADDR));
    rx_cnt_s    = 16'(wr_addr_r) + (wr_fire_s ? 16'd1 : 16'd0);
    accept_s    = (rx_cnt_s != 16'd0) && !ovf_next_s && (rx_cnt_s == udp_rx_data_num);
    rd_fire_s   = (state_r == TX) && udp_tx_req && (req_cnt_r < len_r);
    last_fire_s = rd_fire_s && (req_cnt_r == (len_r - 16'd1));
    extra_req_s = (state_r == TX) && udp_tx_req && !(req_cnt_r < len_r);
    timeout_s   = (state_r == TX) && !udp_tx_req && (idle_cnt_r == TMO_LAST);
    drop_inc_s  = (udp_rx_done && !(rx_phase_s && accept_s)) || timeout_s;
  end

  // Payload buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_addr_r] <= udp_rx_data;
    end
  end

  // Control FSM with all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      wr_addr_r       <= '0;
      rd_addr_r       <= '0;
      ovf_r           <= 1'b0;
      len_r           <= 16'd0;
      req_cnt_r       <= 16'd0;
      idle_cnt_r      <= 16'd0;
      udp_tx_en       <= 1'b0;
      udp_tx_data     <= 8'h00;
      udp_tx_data_num <= 16'd0;
      busy            <= 1'b0;
      echo_cnt        <= 16'd0;
      drop_cnt        <= 16'd0;
    end else begin
      udp_tx_en <= 1'b0;
      if (drop_inc_s) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
      case (state_r)
        IDLE, RX: begin
          if (wr_fire_s) begin
            wr_addr_r <= wr_addr_r + ADDR_W'(1);
          end
          ovf_r <= ovf_next_s;
          if (udp_rx_done) begin
            wr_addr_r <= '0;
            ovf_r     <= 1'b0;
            if (accept_s) begin
              len_r           <= rx_cnt_s;
              udp_tx_data_num <= rx_cnt_s;
              busy            <= 1'b1;
              state_r         <= WAIT_RDY;
            end else begin
              state_r <= IDLE;
            end
          end else if (udp_rx_data_vld) begin
            state_r <= RX;
          end
        end
        WAIT_RDY: begin
          if (tx_rdy) begin
            udp_tx_en  <= 1'b1;
            rd_addr_r  <= '0;
            req_cnt_r  <= 16'd0;
            idle_cnt_r <= 16'd0;
            state_r    <= TX;
          end
        end
        TX: begin
          idle_cnt_r <= udp_tx_req ? 16'd0 : idle_cnt_r + 16'd1;
          if (rd_fire_s) begin
            udp_tx_data <= mem_r[rd_addr_r];
            rd_addr_r   <= rd_addr_r + ADDR_W'(1);
            req_cnt_r   <= req_cnt_r + 16'd1;
          end else if (extra_req_s) begin
            udp_tx_data <= 8'h00;
          end
          // Final byte goes out on the same edge the FSM returns to IDLE.
          if (last_fire_s || timeout_s) begin
            if (last_fire_s) begin
              echo_cnt <= sat_inc(echo_cnt);
            end
            rd_addr_r <= '0;
            req_cnt_r <= 16'd0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
